// File: rtl/timer_driver.sv
// Initiator-side driver for the countdown timer: queues host delay requests,
// issues each to the timer as a one-cycle load, times the done pulse and
// reports the elapsed cycles with ok / timeout status.
module timer_driver #(
  parameter int DEPTH          = 4,
  parameter int LAT_ADJ        = 1,
  parameter int TIMEOUT_MARGIN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [4:0] req_delay,
  output logic       req_ready,
  output logic [4:0] tmr_in,
  output logic       tmr_in_valid,
  input  logic       tmr_out_valid,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_delay,
  output logic [7:0] rsp_elapsed,
  output logic       rsp_ok,
  output logic       rsp_timeout,
  output logic       busy
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
  localparam logic [7:0]  LAT8     = 8'(LAT_ADJ);
  localparam logic [7:0]  MARGIN8  = 8'(TIMEOUT_MARGIN);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} state_e;

  state_e        state_q, state_d;
  logic [4:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [4:0]    cur_delay_q, cur_delay_d;
  logic [4:0]    tmr_in_q, tmr_in_d;
  logic          tmr_in_valid_q, tmr_in_valid_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_elapsed_q, rsp_elapsed_d;
  logic          rsp_ok_q, rsp_ok_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic          req_ready_q, busy_q;
  logic          push, pop;
  logic [4:0]    head;
  logic [7:0]    exp_cnt, limit_cnt;

  // req_ready_q is only ever high when the registered count is below DEPTH.
  assign push      = req_valid && req_ready_q;
  assign head      = mem_q[rd_ptr_q];
  // 8-bit sums never wrap: 31 + LAT_ADJ + TIMEOUT_MARGIN <= 255.
  assign exp_cnt   = {3'b000, cur_delay_q} + LAT8;
  assign limit_cnt = exp_cnt + MARGIN8;

  // FIFO occupancy after this cycle's push and pop.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + ONE_CNT;
    else if (!push && pop) count_d = count_q - ONE_CNT;
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  // NOTE: leaving the memory array out of reset keeps it a plain RAM; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req_delay;
  end

  // Next-state and registered-output logic for the request/response FSM.
  // NOTE: every target gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    cur_delay_d    = cur_delay_q;
    tmr_in_d       = tmr_in_q;
    tmr_in_valid_d = 1'b0;
    cnt_d          = cnt_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_elapsed_d  = rsp_elapsed_q;
    rsp_ok_d       = rsp_ok_q;
    rsp_timeout_d  = rsp_timeout_q;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          cur_delay_d = head;
          if (head != 5'd0) begin
            state_d        = ISSUE;
            tmr_in_d       = head;
            tmr_in_valid_d = 1'b1;
            cnt_d          = 8'd0;
          end else begin
            // The timer ignores a zero load, so report immediately.
            state_d       = REPORT;
            rsp_valid_d   = 1'b1;
            rsp_elapsed_d = 8'd0;
            rsp_ok_d      = 1'b0;
            rsp_timeout_d = 1'b0;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 8'd1;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A done pulse on the limit cycle wins over the timeout.
        if (tmr_out_valid) begin
          state_d       = REPORT;
          rsp_valid_d   = 1'b1;
          rsp_elapsed_d = cnt_q;
          rsp_ok_d      = (cnt_q == exp_cnt);
          rsp_timeout_d = 1'b0;
        end else if (cnt_q >= limit_cnt) begin
          state_d       = REPORT;
          rsp_valid_d   = 1'b1;
          rsp_elapsed_d = cnt_q;
          rsp_ok_d      = 1'b0;
          rsp_timeout_d = 1'b1;
        end
      end
      REPORT: begin
        if (rsp_ready) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b0;
          rsp_ok_d      = 1'b0;
          rsp_timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, FIFO pointers and all registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      cur_delay_q    <= '0;
      tmr_in_q       <= '0;
      tmr_in_valid_q <= 1'b0;
      cnt_q          <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_elapsed_q  <= '0;
      rsp_ok_q       <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      req_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q        <= count_d;
      cur_delay_q    <= cur_delay_d;
      tmr_in_q       <= tmr_in_d;
      tmr_in_valid_q <= tmr_in_valid_d;
      cnt_q          <= cnt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_elapsed_q  <= rsp_elapsed_d;
      rsp_ok_q       <= rsp_ok_d;
      rsp_timeout_q  <= rsp_timeout_d;
      req_ready_q    <= (count_d != FULL_CNT);
      busy_q         <= (state_d != IDLE) || (count_d != '0);
    end
  end

  assign req_ready    = req_ready_q;
  assign tmr_in       = tmr_in_q;
  assign tmr_in_valid = tmr_in_valid_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_delay    = cur_delay_q;
  assign rsp_elapsed  = rsp_elapsed_q;
  assign rsp_ok       = rsp_ok_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_timer_driver.sv
// Directed bench for timer_driver with a behavioural timer model that can
// act as the real timer (answers at delay+1, re-pulses every 32 cycles),
// stay silent, or pulse at a chosen elapsed count.
`timescale 1ns/1ps
module tb_timer_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [4:0] req_delay = 5'd0;
  logic       req_ready;
  logic [4:0] tmr_in;
  logic       tmr_in_valid;
  logic       tmr_out_valid;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [4:0] rsp_delay;
  logic [7:0] rsp_elapsed;
  logic       rsp_ok;
  logic       rsp_timeout;
  logic       busy;

  typedef struct packed {
    logic [4:0] d;
    logic [7:0] el;
    logic       ok;
    logic       to;
  } rsp_t;

  rsp_t        rq[$];
  int          errors = 0;
  int          checks = 0;
  int          iv_cnt = 0;
  logic [4:0]  last_tmr_in = 5'd0;
  int          tmr_mode = 0;   // 0 real timer, 1 silent, 2 pulse at fix_at
  int          fix_at = 0;
  logic        tmr_run;
  int          tmr_since;
  int          tmr_del;
  logic [23:0] outs;

  timer_driver #(.DEPTH(4), .LAT_ADJ(1), .TIMEOUT_MARGIN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_delay(req_delay), .req_ready(req_ready),
    .tmr_in(tmr_in), .tmr_in_valid(tmr_in_valid), .tmr_out_valid(tmr_out_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_delay(rsp_delay),
    .rsp_elapsed(rsp_elapsed), .rsp_ok(rsp_ok), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign outs = {req_ready, tmr_in, tmr_in_valid, rsp_valid, rsp_delay,
                 rsp_elapsed, rsp_ok, rsp_timeout, busy};

  // Timer model: cycle count since the load, 1 in the first cycle after it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_run   <= 1'b0;
      tmr_since <= 0;
      tmr_del   <= 0;
    end else if (tmr_in_valid && tmr_in != 5'd0) begin
      tmr_run   <= 1'b1;
      tmr_since <= 1;
      tmr_del   <= int'(tmr_in);
    end else if (tmr_run) begin
      tmr_since <= tmr_since + 1;
    end
  end

  always_comb begin
    tmr_out_valid = 1'b0;
    if (tmr_run) begin
      case (tmr_mode)
        0: tmr_out_valid = (tmr_since >= tmr_del + 1) && (((tmr_since - tmr_del - 1) % 32) == 0);
        2: tmr_out_valid = (tmr_since == fix_at);
        default: tmr_out_valid = 1'b0;
      endcase
    end
  end

  // Monitors sample mid-cycle, ahead of the edge on which they take effect.
  always @(negedge clk) begin
    if (tmr_in_valid) begin
      iv_cnt      = iv_cnt + 1;
      last_tmr_in = tmr_in;
    end
    if (rst_n && rsp_valid && rsp_ready)
      rq.push_back({rsp_delay, rsp_elapsed, rsp_ok, rsp_timeout});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] d);
    bit done = 1'b0;
    req_valid = 1'b1;
    req_delay = d;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL push_accept: delay %0d not accepted, req_ready=%b expected 1", d, req_ready);
    end
  endtask

  task automatic get_rsp(output rsp_t r, output bit got);
    int n = 0;
    got = 1'b0;
    r   = '0;
    while (rq.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() > 0) begin
      r   = rq.pop_front();
      got = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 000000", outs);
    end
    cyc(2);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_release: got %b expected 0", req_ready);
    end
    cyc(1);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_first_clock: req_ready=%b busy=%b expected 1 0", req_ready, busy);
    end
  endtask

  task automatic test_single();
    rsp_t r;
    bit   got;
    int   iv0;
    rq.delete();
    tmr_mode  = 0;
    rsp_ready = 1'b1;
    iv0 = iv_cnt;
    push(5'd5);
    get_rsp(r, got);
    checks++;
    if (!got || r !== rsp_t'({5'd5, 8'd6, 1'b1, 1'b0})) begin
      errors++;
      $display("FAIL single_rsp: got=%b {d,el,ok,to}=%0d,%0d,%b,%b expected 5,6,1,0", got, r.d, r.el, r.ok, r.to);
    end
    checks++;
    if (iv_cnt - iv0 !== 1) begin
      errors++;
      $display("FAIL single_load_width: tmr_in_valid high %0d cycles expected 1", iv_cnt - iv0);
    end
    checks++;
    if (last_tmr_in !== 5'd5) begin
      errors++;
      $display("FAIL single_tmr_in: got %0d expected 5", last_tmr_in);
    end
  endtask

  task automatic test_back_to_back();
    rsp_t r;
    bit   got;
    rsp_t exp_q [3];
    exp_q[0] = {5'd1,  8'd2,  1'b1, 1'b0};
    exp_q[1] = {5'd31, 8'd32, 1'b1, 1'b0};
    exp_q[2] = {5'd2,  8'd3,  1'b1, 1'b0};
    rq.delete();
    tmr_mode  = 0;
    rsp_ready = 1'b1;
    push(5'd1);
    push(5'd31);
    push(5'd2);
    for (int i = 0; i < 3; i++) begin
      get_rsp(r, got);
      checks++;
      if (!got || r !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_rsp%0d: got=%b {d,el,ok,to}=%0d,%0d,%b,%b expected %0d,%0d,%b,%b",
                 i, got, r.d, r.el, r.ok, r.to, exp_q[i].d, exp_q[i].el, exp_q[i].ok, exp_q[i].to);
      end
    end
    // Idle through two stray timer re-pulses; nothing may move.
    cyc(70);
    checks++;
    if (rq.size() !== 0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_pulse_idle: extra_rsp=%0d rsp_valid=%b busy=%b expected 0 0 0", rq.size(), rsp_valid, busy);
    end
    checks++;
    if ({rsp_delay, rsp_elapsed, rsp_ok, rsp_timeout} !== {5'd2, 8'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stray_pulse_fields: d=%0d el=%0d ok=%b to=%b expected 2 3 0 0", rsp_delay, rsp_elapsed, rsp_ok, rsp_timeout);
    end
  endtask

  task automatic test_timeout();
    rsp_t r;
    bit   got;
    rq.delete();
    rsp_ready = 1'b1;
    tmr_mode  = 1;
    push(5'd3);
    get_rsp(r, got);
    checks++;
    if (!got || r !== rsp_t'({5'd3, 8'd8, 1'b0, 1'b1})) begin
      errors++;
      $display("FAIL timeout_silent: got=%b {d,el,ok,to}=%0d,%0d,%b,%b expected 3,8,0,1", got, r.d, r.el, r.ok, r.to);
    end
    tmr_mode = 2;
    fix_at   = 8;
    push(5'd3);
    get_rsp(r, got);
    checks++;
    if (!got || r !== rsp_t'({5'd3, 8'd8, 1'b0, 1'b0})) begin
      errors++;
      $display("FAIL pulse_at_limit: got=%b {d,el,ok,to}=%0d,%0d,%b,%b expected 3,8,0,0", got, r.d, r.el, r.ok, r.to);
    end
    fix_at = 2;
    push(5'd5);
    get_rsp(r, got);
    checks++;
    if (!got || r !== rsp_t'({5'd5, 8'd2, 1'b0, 1'b0})) begin
      errors++;
      $display("FAIL early_pulse: got=%b {d,el,ok,to}=%0d,%0d,%b,%b expected 5,2,0,0", got, r.d, r.el, r.ok, r.to);
    end
    tmr_mode = 0;
  endtask

  task automatic test_backpressure();
    rsp_t r;
    rsp_t first;
    bit   got;
    int   n = 0;
    rq.delete();
    tmr_mode  = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(5'd1);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_after_5: req_ready=%b expected 0", req_ready);
    end
    while (!rsp_valid && n < 100) begin
      cyc(1);
      n++;
    end
    first = {rsp_delay, rsp_elapsed, rsp_ok, rsp_timeout};
    checks++;
    if (rsp_valid !== 1'b1 || first !== rsp_t'({5'd1, 8'd2, 1'b1, 1'b0})) begin
      errors++;
      $display("FAIL held_first: rsp_valid=%b {d,el,ok,to}=%0d,%0d,%b,%b expected 1 with 1,2,1,0",
               rsp_valid, first.d, first.el, first.ok, first.to);
    end
    // Hold long enough for a timer re-pulse to land while reporting.
    cyc(40);
    checks++;
    if ({rsp_valid, rsp_delay, rsp_elapsed, rsp_ok, rsp_timeout} !== {1'b1, 5'd1, 8'd2, 1'b1, 1'b0} || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL held_stable: rsp_valid=%b d=%0d el=%0d ok=%b to=%b req_ready=%b expected 1 1 2 1 0 0",
               rsp_valid, rsp_delay, rsp_elapsed, rsp_ok, rsp_timeout, req_ready);
    end
    fork
      push(5'd1);
      begin
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
          get_rsp(r, got);
          checks++;
          if (!got || r !== rsp_t'({5'd1, 8'd2, 1'b1, 1'b0})) begin
            errors++;
            $display("FAIL drain_rsp%0d: got=%b {d,el,ok,to}=%0d,%0d,%b,%b expected 1,2,1,0",
                     i, got, r.d, r.el, r.ok, r.to);
          end
        end
      end
    join
    cyc(5);
    checks++;
    if (busy !== 1'b0 || rq.size() !== 0) begin
      errors++;
      $display("FAIL drain_done: busy=%b extra_rsp=%0d expected 0 0", busy, rq.size());
    end
  endtask

  task automatic test_zero_delay();
    rsp_t r;
    bit   got;
    int   iv0;
    rq.delete();
    rsp_ready = 1'b1;
    iv0 = iv_cnt;
    push(5'd0);
    get_rsp(r, got);
    checks++;
    if (!got || r !== rsp_t'({5'd0, 8'd0, 1'b0, 1'b0})) begin
      errors++;
      $display("FAIL zero_rsp: got=%b {d,el,ok,to}=%0d,%0d,%b,%b expected 0,0,0,0", got, r.d, r.el, r.ok, r.to);
    end
    checks++;
    if (iv_cnt - iv0 !== 0) begin
      errors++;
      $display("FAIL zero_no_load: tmr_in_valid high %0d cycles expected 0", iv_cnt - iv0);
    end
  endtask

  task automatic test_reset_mid_wait();
    rsp_t r;
    bit   got;
    rq.delete();
    tmr_mode  = 0;
    rsp_ready = 1'b1;
    push(5'd20);
    cyc(10);
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 24'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h expected 000000", outs);
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    checks++;
    if (rq.size() !== 0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_no_rsp: extra_rsp=%0d rsp_valid=%b expected 0 0", rq.size(), rsp_valid);
    end
    push(5'd4);
    get_rsp(r, got);
    checks++;
    if (!got || r !== rsp_t'({5'd4, 8'd5, 1'b1, 1'b0})) begin
      errors++;
      $display("FAIL after_reset_rsp: got=%b {d,el,ok,to}=%0d,%0d,%b,%b expected 4,5,1,0", got, r.d, r.el, r.ok, r.to);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_zero_delay();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
